// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch stage.
package ifetch_pkg;

    // Canonical RISC-V nop (addi x0, x0, 0) shown to decode while idle.
    localparam logic [31:0] RV_NOP           = 32'h0000_0013;
    localparam logic [31:0] RV_RESET_VECTOR  = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_REQ  = 2'd0,
        IF_WAIT = 2'd1,
        IF_HOLD = 2'd2
    } if_state_e;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, keeps at most one fetch in flight,
// buffers one instruction for decode and squashes fetches on redirect.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RV_RESET_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] ir_pc_q, ir_pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic        kill_q, kill_d;

    // The low redirect bits are discarded by word alignment.
    logic [1:0]  unused_redirect_lsb;
    assign unused_redirect_lsb = redirect_pc[1:0];

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IF_REQ;
            pc_q       <= RESET_PC;
            ir_q       <= RV_NOP;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            kill_q     <= kill_d;
        end
    end

    // Next-state logic; a redirect overrides everything else in any state.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        kill_d     = kill_q;

        if (redirect_valid) begin
            pc_d       = word_align(redirect_pc);
            ir_valid_d = 1'b0;
            unique case (state_q)
                IF_REQ: begin
                    // A fetch granted this cycle is still owed a response.
                    if (imem_gnt) begin
                        kill_d  = 1'b1;
                        state_d = IF_WAIT;
                    end else begin
                        state_d = IF_REQ;
                    end
                end
                IF_WAIT: begin
                    // A response arriving now is the stale one; drop it.
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = IF_REQ;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end
                IF_HOLD: begin
                    state_d = IF_REQ;
                end
                default: begin
                    state_d = IF_REQ;
                end
            endcase
        end else begin
            unique case (state_q)
                IF_REQ: begin
                    if (imem_gnt) begin
                        state_d = IF_WAIT;
                    end
                end
                IF_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = IF_REQ;
                        end else begin
                            ir_d       = imem_rdata;
                            ir_pc_d    = pc_q;
                            ir_valid_d = 1'b1;
                            pc_d       = pc_q + 32'd4;
                            state_d    = IF_HOLD;
                        end
                    end
                end
                IF_HOLD: begin
                    if (ir_ready) begin
                        ir_valid_d = 1'b0;
                        state_d    = IF_REQ;
                    end
                end
                default: begin
                    state_d = IF_REQ;
                end
            endcase
        end
    end

    assign imem_req  = (state_q == IF_REQ);
    assign imem_addr = pc_q;
    assign ir_valid  = ir_valid_q;
    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: table of plain fetches plus hand-written
// redirect and reset sequences, driven against a simple memory responder.
module tb_ifetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ifetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .ir             (ir),
        .ir_pc          (ir_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) + 32'h0000_1234;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One complete fetch: gd cycles without grant, response rd cycles after
    // grant (rd>=1), decode stalls yd cycles before accepting.
    task automatic do_fetch(input int gd, input int rd, input int yd, input logic [31:0] exp);
        for (int i = 0; i < gd; i++) begin
            chk("req_wait_gnt", {31'd0, imem_req}, 32'd1);
            chk("addr_wait_gnt", imem_addr, exp);
            imem_gnt = 1'b0;
            step();
        end
        chk("req", {31'd0, imem_req}, 32'd1);
        chk("addr", imem_addr, exp);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        for (int i = 0; i < rd - 1; i++) begin
            chk("req_in_wait", {31'd0, imem_req}, 32'd0);
            chk("irv_in_wait", {31'd0, ir_valid}, 32'd0);
            step();
        end
        imem_rvalid = 1'b1;
        imem_rdata  = mem(exp);
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        chk("ir_valid", {31'd0, ir_valid}, 32'd1);
        chk("ir", ir, mem(exp));
        chk("ir_pc", ir_pc, exp);
        for (int i = 0; i < yd; i++) begin
            ir_ready = 1'b0;
            step();
            chk("hold_irv", {31'd0, ir_valid}, 32'd1);
            chk("hold_ir", ir, mem(exp));
            chk("hold_ir_pc", ir_pc, exp);
            chk("hold_req", {31'd0, imem_req}, 32'd0);
        end
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        chk("irv_after_consume", {31'd0, ir_valid}, 32'd0);
        chk("req_after_consume", {31'd0, imem_req}, 32'd1);
    endtask

    typedef struct {
        int          gnt_dly;
        int          rv_dly;
        int          rdy_dly;
        logic [31:0] exp_addr;
    } fetch_vec_t;

    fetch_vec_t vecs [7];

    initial begin
        // Sequential fetches: back-to-back, decode stall, grant stall, slow response.
        vecs[0] = '{0, 1, 0, 32'h0000_0000};
        vecs[1] = '{0, 1, 0, 32'h0000_0004};
        vecs[2] = '{0, 1, 0, 32'h0000_0008};
        vecs[3] = '{0, 1, 5, 32'h0000_000C};
        vecs[4] = '{0, 1, 0, 32'h0000_0010};
        vecs[5] = '{3, 1, 0, 32'h0000_0014};
        vecs[6] = '{0, 2, 1, 32'h0000_0018};

        rst = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        ir_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        step();
        step();
        chk("rst_irv", {31'd0, ir_valid}, 32'd0);
        chk("rst_ir", ir, NOP);
        chk("rst_ir_pc", ir_pc, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd1);
        chk("rst_addr", imem_addr, 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++)
            do_fetch(vecs[v].gnt_dly, vecs[v].rv_dly, vecs[v].rdy_dly, vecs[v].exp_addr);

        // A response strobe while requesting is ignored.
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        chk("stray_rv_req", {31'd0, imem_req}, 32'd1);
        chk("stray_rv_addr", imem_addr, 32'h0000_001C);
        chk("stray_rv_irv", {31'd0, ir_valid}, 32'd0);

        // Redirect during WAIT; stale response 4 cycles after grant.
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        chk("rdw_req", {31'd0, imem_req}, 32'd0);
        chk("rdw_irv", {31'd0, ir_valid}, 32'd0);
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = mem(32'h0000_001C);
        step();
        imem_rvalid = 1'b0;
        chk("rdw_stale_irv", {31'd0, ir_valid}, 32'd0);
        chk("rdw_req2", {31'd0, imem_req}, 32'd1);
        chk("rdw_addr", imem_addr, 32'h0000_0100);
        do_fetch(0, 1, 0, 32'h0000_0100);

        // Redirect in the same cycle the request is granted.
        imem_gnt = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0300;
        step();
        imem_gnt = 1'b0;
        redirect_valid = 1'b0;
        chk("rdg_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = mem(32'h0000_0104);
        step();
        imem_rvalid = 1'b0;
        chk("rdg_irv", {31'd0, ir_valid}, 32'd0);
        chk("rdg_req2", {31'd0, imem_req}, 32'd1);
        chk("rdg_addr", imem_addr, 32'h0000_0300);
        do_fetch(0, 1, 0, 32'h0000_0300);

        // Redirect to unaligned 0x203 coinciding with rvalid in WAIT.
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = mem(32'h0000_0304);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0203;
        step();
        imem_rvalid = 1'b0;
        redirect_valid = 1'b0;
        chk("rdr_irv", {31'd0, ir_valid}, 32'd0);
        chk("rdr_req", {31'd0, imem_req}, 32'd1);
        chk("rdr_addr", imem_addr, 32'h0000_0200);

        // Redirect coinciding with ir_ready in HOLD drops the buffered word.
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = mem(32'h0000_0200);
        step();
        imem_rvalid = 1'b0;
        chk("rdh_irv_before", {31'd0, ir_valid}, 32'd1);
        ir_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0203;
        step();
        ir_ready = 1'b0;
        redirect_valid = 1'b0;
        chk("rdh_irv", {31'd0, ir_valid}, 32'd0);
        chk("rdh_req", {31'd0, imem_req}, 32'd1);
        chk("rdh_addr", imem_addr, 32'h0000_0200);
        do_fetch(0, 1, 0, 32'h0000_0200);

        // PC wrap from the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        do_fetch(0, 1, 0, 32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'h0000_0000);

        // Reset while waiting for a response.
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_irv", {31'd0, ir_valid}, 32'd0);
        chk("mrst_ir", ir, NOP);
        chk("mrst_ir_pc", ir_pc, 32'd0);
        chk("mrst_req", {31'd0, imem_req}, 32'd1);
        chk("mrst_addr", imem_addr, 32'd0);
        do_fetch(0, 1, 0, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
